tone_synth: RTL and testbench

Streaming square-wave synthesizer with a linear attack/release envelope. It turns the tone request from the sound-effect sequencer into signed 24-bit samples for the audio codec interface. It sits directly downstream of the sequencer: `write_en`/`freq` come in, and it drives the codec's `write`/`writedata_left`/`writedata_right` handshake at the codec's own sample pace. The envelope ramps the level up and down so tone start, end and frequency changes are click-free.

---
 rtl/tone_synth.sv | 144 ++++++++++++++
 tb/tb_tone_synth.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_synth.sv
// rtl/tone_synth.sv - square-wave tone synthesizer with linear attack/release envelope
module tone_synth #(
    parameter int          SAMPLE_RATE = 48000,
    parameter logic [23:0] AMPLITUDE   = 24'h100000,
    parameter logic [23:0] STEP        = 24'h000400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_en,
    input  logic [19:0] freq,
    input  logic        write_ready,
    output logic        write,
    output logic [23:0] writedata_left,
    output logic [23:0] writedata_right
);

    localparam int          HALF   = SAMPLE_RATE / 2;
    localparam logic [20:0] HALF21 = 21'(HALF);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ATTACK,
        S_SUSTAIN,
        S_RELEASE
    } state_t;

    state_t      state, state_nx;
    logic [23:0] level, level_nx;
    logic        pol, pol_nx;
    logic [16:0] acc, acc_nx;
    logic [19:0] freq_q, freq_q_nx;

    logic        accept;
    logic        fvalid;
    logic [20:0] sum;
    logic [23:0] sample;

    // The codec sets the pace: every cycle out of reset offers a sample.
    assign write  = write_ready & ~reset;
    assign accept = write_ready & ~reset;

    // Zero or at/above Nyquist is treated as "no tone" and forces a release.
    assign fvalid = (freq_q != 20'd0) && (21'(freq_q) < HALF21);

    // acc stays below HALF, so this never overflows 21 bits.
    assign sum = 21'(acc) + 21'(freq_q);

    // Registered state; everything else is derived combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            level  <= 24'd0;
            pol    <= 1'b1;
            acc    <= 17'd0;
            freq_q <= 20'd0;
        end else begin
            state  <= state_nx;
            level  <= level_nx;
            pol    <= pol_nx;
            acc    <= acc_nx;
            freq_q <= freq_q_nx;
        end
    end

    // Next-state: Bresenham phase stepping, then the envelope FSM.
    always_comb begin
        state_nx  = state;
        level_nx  = level;
        pol_nx    = pol;
        acc_nx    = acc;
        freq_q_nx = freq_q;

        // New frequencies are only picked up at a half-period edge so the
        // running half-cycle is never shortened or stretched mid-way.
        if (accept && (state != S_IDLE)) begin
            if (!fvalid) begin
                freq_q_nx = freq;
            end else if (sum >= HALF21) begin
                acc_nx    = 17'(sum - HALF21);
                pol_nx    = ~pol;
                freq_q_nx = freq;
            end else begin
                acc_nx    = sum[16:0];
            end
        end

        case (state)
            S_IDLE: begin
                level_nx = 24'd0;
                pol_nx   = 1'b1;
                acc_nx   = 17'd0;
                if (write_en) begin
                    freq_q_nx = freq;
                    state_nx  = S_ATTACK;
                end
            end
            S_ATTACK: begin
                if (!write_en || !fvalid) begin
                    state_nx = S_RELEASE;
                end else if (accept) begin
                    if (level >= AMPLITUDE - STEP) begin
                        level_nx = AMPLITUDE;
                        state_nx = S_SUSTAIN;
                    end else begin
                        level_nx = level + STEP;
                    end
                end
            end
            S_SUSTAIN: begin
                level_nx = AMPLITUDE;
                if (!write_en || !fvalid) begin
                    state_nx = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // Retrigger keeps level and phase so the restart is click-free.
                if (write_en && fvalid) begin
                    state_nx = S_ATTACK;
                end else if (accept) begin
                    if (level <= STEP) begin
                        level_nx = 24'd0;
                        state_nx = S_IDLE;
                        acc_nx   = 17'd0;
                        pol_nx   = 1'b1;
                    end else begin
                        level_nx = level - STEP;
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Signed sample from polarity and magnitude; zero level gives zero output.
    always_comb begin
        sample = pol ? level : (24'd0 - level);
    end

    assign writedata_left  = sample;
    assign writedata_right = sample;

endmodule

// File: tb/tb_tone_synth.sv
// tb/tb_tone_synth.sv - randomized self-checking bench for tone_synth
module tb_tone_synth;

    localparam int HALF   = 24000;
    localparam int AMP    = 32'h100000;
    localparam int STEP_I = 32'h000400;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        write_en = 1'b0;
    logic [19:0] freq = 20'd0;
    logic        write_ready = 1'b0;
    logic        write;
    logic [23:0] writedata_left;
    logic [23:0] writedata_right;

    int errors = 0;
    int checks = 0;

    tone_synth dut (
        .clk             (clk),
        .reset           (reset),
        .write_en        (write_en),
        .freq            (freq),
        .write_ready     (write_ready),
        .write           (write),
        .writedata_left  (writedata_left),
        .writedata_right (writedata_right)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Hard stop if the run ever stalls
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Sample after n phase-accumulating accepts at constant frequency f:
    // polarity flips once per completed half-period, i.e. floor(n*f/HALF) times.
    function automatic logic [23:0] model_sample(input longint n, input int f, input int lvl);
        longint      tog;
        logic [23:0] l;
        tog = (n * longint'(f)) / HALF;
        l   = 24'(lvl);
        return (tog % 2 == 0) ? l : (24'd0 - l);
    endfunction

    function automatic int mag(input logic [23:0] x);
        logic [23:0] m;
        m = x[23] ? (24'd0 - x) : x;
        return int'(m);
    endfunction

    function automatic int ramp_up(input int n);
        return (n * STEP_I > AMP) ? AMP : n * STEP_I;
    endfunction

    task automatic tick(input logic rdy);
        write_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        write_en = 1'b0;
        freq     = 20'd0;
        tick(1'b1);
        tick(1'b1);
        reset    = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        write_en = 1'b0;
        freq     = 20'd0;
        tick(1'b1);
        checks++;
        if (write !== 1'b0 || writedata_left !== 24'd0 || writedata_right !== 24'd0) begin
            errors++;
            $display("FAIL reset_hold: write=%b left=%h right=%h, want write=0 data=0",
                     write, writedata_left, writedata_right);
        end
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1'b1);
            checks++;
            if (write !== 1'b1 || writedata_left !== 24'd0 || writedata_right !== 24'd0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: write=%b left=%h right=%h, want write=1 data=0",
                         i, write, writedata_left, writedata_right);
            end
        end
    endtask

    // mode 0: always ready, 1: ready one cycle in four, 2: random ready
    task automatic run_tone(input int f, input int n_acc, input int mode, input string name);
        int          n;
        int          cyc;
        logic        rdy;
        logic [23:0] exp_s;
        do_reset();
        freq     = 20'(f);
        write_en = 1'b1;
        tick(1'b0);
        n   = 0;
        cyc = 0;
        while (n < n_acc) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0);
                default: rdy = ($urandom_range(0, 2) != 0);
            endcase
            tick(rdy);
            cyc++;
            if (rdy) n++;
            exp_s = model_sample(n, f, ramp_up(n));
            checks++;
            if (writedata_left !== exp_s || writedata_right !== exp_s || write !== rdy) begin
                errors++;
                $display("FAIL %s f=%0d n=%0d: left=%h right=%h write=%b, want data=%h write=%b",
                         name, f, n, writedata_left, writedata_right, write, exp_s, rdy);
            end
        end
    endtask

    task automatic test_basic_tone();
        run_tone(6000, 1100, 0, "basic_tone");
    endtask

    task automatic test_backpressure();
        run_tone(6000, 1100, 1, "backpressure");
    endtask

    task automatic test_random_tones();
        for (int r = 0; r < 4; r++) begin
            run_tone(int'($urandom_range(1, HALF - 1)), int'($urandom_range(300, 1200)), 2, "random_tone");
        end
    endtask

    task automatic test_bresenham();
        int   toggles;
        int   last_t;
        logic prev_sgn;
        do_reset();
        freq     = 20'd523;
        write_en = 1'b1;
        tick(1'b0);
        toggles  = 0;
        last_t   = -1;
        prev_sgn = 1'b0;
        for (int i = 1; i <= 48000; i++) begin
            tick(1'b1);
            if (writedata_left[23] !== prev_sgn) begin
                toggles++;
                if (last_t >= 0) begin
                    checks++;
                    if (i - last_t != 45 && i - last_t != 46) begin
                        errors++;
                        $display("FAIL bresenham_interval: got %0d samples at sample %0d, want 45 or 46",
                                 i - last_t, i);
                    end
                end
                last_t   = i;
                prev_sgn = writedata_left[23];
            end
        end
        checks++;
        if (toggles < 1045 || toggles > 1047) begin
            errors++;
            $display("FAIL bresenham_count: got %0d toggles, want 1046 +/-1", toggles);
        end
    endtask

    task automatic test_release_retrigger();
        int          n;
        int          lvl;
        logic [23:0] exp_s;
        do_reset();
        freq     = 20'd523;
        write_en = 1'b1;
        tick(1'b0);
        n = 0;
        // climb to 0x040000
        for (int j = 1; j <= 24'h040000 / STEP_I; j++) begin
            tick(1'b1);
            n++;
        end
        lvl      = 24'h040000;
        write_en = 1'b0;
        tick(1'b0);
        exp_s = model_sample(n, 523, lvl);
        checks++;
        if (writedata_left !== exp_s) begin
            errors++;
            $display("FAIL release_enter: got %h, want %h", writedata_left, exp_s);
        end
        for (int j = 1; j <= 24'h040000 / STEP_I; j++) begin
            tick(1'b1);
            n++;
            lvl   = 24'h040000 - j * STEP_I;
            exp_s = model_sample(n, 523, lvl);
            checks++;
            if (writedata_left !== exp_s || writedata_right !== exp_s) begin
                errors++;
                $display("FAIL release_ramp j=%0d: got %h, want %h", j, writedata_left, exp_s);
            end
        end
        for (int j = 0; j < 10; j++) begin
            tick(1'b1);
            checks++;
            if (writedata_left !== 24'd0) begin
                errors++;
                $display("FAIL release_silent j=%0d: got %h, want 0", j, writedata_left);
            end
        end
        // A fresh start from IDLE has reset phase: first sample is +STEP.
        write_en = 1'b1;
        tick(1'b0);
        tick(1'b1);
        n = 1;
        checks++;
        if (writedata_left !== 24'(STEP_I)) begin
            errors++;
            $display("FAIL idle_restart: got %h, want %h", writedata_left, 24'(STEP_I));
        end
        for (int j = 2; j <= 24'h040000 / STEP_I; j++) begin
            tick(1'b1);
            n++;
        end
        write_en = 1'b0;
        tick(1'b0);
        for (int j = 1; j <= 24'h020000 / STEP_I; j++) begin
            tick(1'b1);
            n++;
        end
        write_en = 1'b1;
        tick(1'b0);
        for (int j = 1; j <= 100; j++) begin
            tick(1'b1);
            n++;
            lvl   = 24'h020000 + j * STEP_I;
            exp_s = model_sample(n, 523, lvl);
            checks++;
            if (writedata_left !== exp_s) begin
                errors++;
                $display("FAIL retrigger_climb j=%0d: got %h, want %h", j, writedata_left, exp_s);
            end
        end
    endtask

    task automatic test_freq_change();
        int   q[$];
        int   k;
        logic prev_sgn;
        do_reset();
        freq     = 20'd523;
        write_en = 1'b1;
        tick(1'b0);
        prev_sgn = 1'b0;
        for (int i = 1; i <= 1430; i++) begin
            if (i == 1031) freq = 20'd262;
            tick(1'b1);
            if (writedata_left[23] !== prev_sgn) begin
                q.push_back(i);
                prev_sgn = writedata_left[23];
            end
        end
        k = -1;
        for (int i = 0; i < q.size(); i++) begin
            if (k < 0 && q[i] > 1030) k = i;
        end
        checks++;
        if (k < 1 || q.size() < k + 4) begin
            errors++;
            $display("FAIL freq_change_toggles: got %0d toggles, first after change at index %0d", q.size(), k);
        end else begin
            checks++;
            if (q[k] - q[k-1] < 45 || q[k] - q[k-1] > 46) begin
                errors++;
                $display("FAIL freq_change_old: got interval %0d, want 45..46", q[k] - q[k-1]);
            end
            checks++;
            if (q[k+1] - q[k] < 90 || q[k+1] - q[k] > 92) begin
                errors++;
                $display("FAIL freq_change_first: got interval %0d, want 90..92", q[k+1] - q[k]);
            end
            for (int i = k + 2; i < k + 4; i++) begin
                checks++;
                if (q[i] - q[i-1] < 91 || q[i] - q[i-1] > 92) begin
                    errors++;
                    $display("FAIL freq_change_new: got interval %0d, want 91..92", q[i] - q[i-1]);
                end
            end
        end
    endtask

    task automatic test_invalid_freq();
        int   toggles;
        logic prev_sgn;
        do_reset();
        freq     = 20'd523;
        write_en = 1'b1;
        tick(1'b0);
        for (int i = 0; i < 1030; i++) tick(1'b1);
        prev_sgn = writedata_left[23];
        freq     = 20'd0;
        toggles  = 0;
        for (int i = 0; i < 1200; i++) begin
            tick(1'b1);
            if (mag(writedata_left) != 0 && writedata_left[23] !== prev_sgn) begin
                toggles++;
                prev_sgn = writedata_left[23];
            end
        end
        checks++;
        if (toggles > 1) begin
            errors++;
            $display("FAIL invalid_toggles: got %0d toggles after freq=0, want at most 1", toggles);
        end
        for (int i = 0; i < 50; i++) begin
            tick(1'b1);
            checks++;
            if (writedata_left !== 24'd0) begin
                errors++;
                $display("FAIL invalid_zero i=%0d: got %h, want 0", i, writedata_left);
            end
        end
        do_reset();
        freq     = 20'd30000;
        write_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick(1'b1);
            checks++;
            if (writedata_left !== 24'd0 || writedata_right !== 24'd0) begin
                errors++;
                $display("FAIL invalid_high i=%0d: got %h, want 0", i, writedata_left);
            end
        end
    endtask

    task automatic test_reset_mid_tone();
        do_reset();
        freq     = 20'd6000;
        write_en = 1'b1;
        tick(1'b0);
        for (int i = 0; i < 1100; i++) tick(1'b1);
        checks++;
        if (mag(writedata_left) != AMP) begin
            errors++;
            $display("FAIL sustain_level: got %h magnitude, want %h", mag(writedata_left), AMP);
        end
        reset = 1'b1;
        tick(1'b1);
        checks++;
        if (writedata_left !== 24'd0 || writedata_right !== 24'd0 || write !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: left=%h right=%h write=%b, want data=0 write=0",
                     writedata_left, writedata_right, write);
        end
        reset    = 1'b0;
        write_en = 1'b0;
        tick(1'b1);
        checks++;
        if (writedata_left !== 24'd0 || write !== 1'b1) begin
            errors++;
            $display("FAIL reset_after: left=%h write=%b, want data=0 write=1", writedata_left, write);
        end
    endtask

    initial begin
        test_reset();
        test_basic_tone();
        test_backpressure();
        test_random_tones();
        test_release_retrigger();
        test_freq_change();
        test_invalid_freq();
        test_reset_mid_tone();
        test_bresenham();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
